tx_sequencer: RTL and testbench
===============================

TX_SEQUENCER -- requirements
Module: tx_sequencer

Interface
REQ-001 SHALL have parameter MAX_DIM, default 11, the maximum board rows/columns supported.
REQ-002 SHALL have parameter ADDR_W, default 7, the cell address width, with MAX_DIM*MAX_DIM <= 2**ADDR_W.
REQ-003 SHALL have port clk_100mhz  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to transmit the solved board.
REQ-006 SHALL have ports n and m  input  4 each  board rows and columns, sampled on an accepted start.
REQ-007 SHALL have port cell_addr  output  ADDR_W  board read address, equal to row*m + col.
REQ-008 SHALL have port cell_val  input  1  cell value, valid exactly one cycle after cell_addr is presented.
REQ-009 SHALL have port tx_valid  output  1  single-cycle byte strobe to the UART transmitter.
REQ-010 SHALL have port tx_data  output  8  byte to send, valid while tx_valid=1.
REQ-011 SHALL have port tx_done  input  1  single-cycle pulse from the UART transmitter when the byte completes.
REQ-012 SHALL have port busy  output  1  high from an accepted start until the frame finishes.
REQ-013 SHALL have port finished  output  1  single-cycle pulse after the last byte's tx_done.

Function
REQ-014 Frame order SHALL be: header byte {n,m}; then ceil(n*m/8) data bytes; then a checksum byte equal to the XOR of all preceding frame bytes.
REQ-015 Data bytes SHALL pack cells in row-major order, LSB first; unused bits of the final byte SHALL be 0.
REQ-016 States SHALL be IDLE, HEADER, GATHER, SEND, WAIT_DONE, CHECKSUM and FINISH.
REQ-017 IDLE→HEADER SHALL occur on start; start SHALL be ignored while busy=1.
REQ-018 HEADER SHALL drive tx_valid for one cycle, then move to WAIT_DONE.
REQ-019 GATHER SHALL present one address per cycle and capture cell_val one cycle later; k cells SHALL take exactly k+1 cycles.
REQ-020 SEND SHALL pulse tx_valid once with the gathered byte, then move to WAIT_DONE.
REQ-021 WAIT_DONE SHALL exit on tx_done to:
- GATHER, if cells remain;
- CHECKSUM, if no cells remain;
- FINISH, after the checksum byte.
REQ-022 tx_valid SHALL NOT be asserted again earlier than the cycle after tx_done; at most one byte SHALL be outstanding.
REQ-023 A tx_done arriving outside WAIT_DONE SHALL be ignored.
REQ-024 FINISH SHALL pulse finished for one cycle and return to IDLE with busy=0.
REQ-025 If n=0 or m=0, the frame SHALL be the header followed by the checksum only (zero data bytes).
REQ-026 n or m greater than MAX_DIM SHALL be treated as zero dimensions.
REQ-027 The cell counter SHALL be ADDR_W+1 bits wide so that n*m=MAX_DIM² does not wrap.
REQ-028 tx_data SHALL hold its value from the tx_valid cycle until the next tx_valid.

Reset
REQ-029 rst SHALL drive all outputs to 0 (tx_valid, tx_data, busy, finished, cell_addr) and the state to IDLE.
REQ-030 rst asserted mid-frame SHALL abort the frame immediately with no further tx_valid; a later tx_done SHALL be ignored.
REQ-031 rst SHALL clear the checksum accumulator and the cell counter.

Structure
REQ-032 MAX_DIM, the state enum and the frame-format constants (header layout, checksum rule) SHALL live in a shared package, nonogram_pkg, for use by the parser and the PC-side tests.
REQ-033 The block SHALL be a single FSM module.
REQ-034 A sub-module, bit_packer (an 8-bit shift-in byte assembler with a count), SHALL be used for byte assembly.

Verification
REQ-035 11x11 all-ones board, tx_done 10 cycles after each tx_valid → bytes 0xBB, 0xFF×15, 0x01, checksum 0x45; finished pulses once.
REQ-036 2x3 board, rows 101/010 → bytes 0x23, 0x15, 0x36.
REQ-037 n=0, m=5 → bytes 0x05, 0x05; no cell_addr activity.
REQ-038 start pulsed again during the fourth byte → the frame is unchanged and exactly one finished pulse occurs.
REQ-039 rst asserted in WAIT_DONE of the third byte → tx_valid=0 and busy=0 that cycle; no further tx_valid, even when a stale tx_done arrives.
REQ-040 tx_done held low for 1000 cycles → the block stays in WAIT_DONE with busy=1 and no extra tx_valid.

Source files
------------

// File: rtl/nonogram_pkg.sv
// nonogram_pkg: board limits, sequencer states and frame format shared
// by the parser, the transmit sequencer and the PC-side tests.
package nonogram_pkg;

  localparam int NG_MAX_DIM        = 11;
  localparam int NG_ADDR_W         = 7;
  localparam int NG_CELLS_PER_BYTE = 8;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    GATHER,
    SEND,
    WAIT_DONE,
    CHECKSUM,
    FINISH
  } tx_state_e;

  // Header byte: rows in the high nibble, columns in the low nibble.
  function automatic logic [7:0] hdr_byte(
    input logic [3:0] rows,
    input logic [3:0] cols
  );
    return {rows, cols};
  endfunction

  // Checksum is the running XOR of every byte sent before it.
  function automatic logic [7:0] csum_next(
    input logic [7:0] acc,
    input logic [7:0] b
  );
    return acc ^ b;
  endfunction

endpackage

// File: rtl/bit_packer.sv
// bit_packer: assembles up to eight cell bits into a byte, LSB first.
// Bits not yet shifted in stay 0, so a short final byte is zero padded.
module bit_packer (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic [7:0] byte_out,
  output logic [3:0] count
);

  // Write each incoming bit at the next free position and count it.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      byte_out <= '0;
      count    <= '0;
    end else if (clear) begin
      byte_out <= '0;
      count    <= '0;
    end else if (shift_en && count < 4'd8) begin
      byte_out[count[2:0]] <= bit_in;
      count                <= count + 4'd1;
    end
  end

endmodule

// File: rtl/tx_sequencer.sv
// tx_sequencer: streams a solved board to the UART as
// header {n,m}, packed cell bytes, then an XOR checksum byte.
module tx_sequencer
  import nonogram_pkg::*;
#(
  parameter int MAX_DIM = NG_MAX_DIM,
  parameter int ADDR_W  = NG_ADDR_W
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        n,
  input  logic [3:0]        m,
  output logic [ADDR_W-1:0] cell_addr,
  input  logic              cell_val,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              finished
);

  localparam int            CW       = ADDR_W + 1;
  localparam logic [3:0]    DIM_LIM  = 4'(MAX_DIM);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    BYTE_LEN = 4'(NG_CELLS_PER_BYTE);

  tx_state_e     state;
  tx_state_e     nxt;
  logic [CW-1:0] cell_idx;
  logic [CW-1:0] total;
  logic [CW-1:0] total_d;
  logic [7:0]    prod;
  logic          dims_ok;
  logic [7:0]    hdr_q;
  logic [7:0]    csum;
  logic          last_q;
  logic          cap_pend;
  logic          issue;
  logic          pk_clear;
  logic [7:0]    pk_byte;
  logic [3:0]    pk_cnt;

  // Board size at the start request; oversize boards carry no cells.
  always_comb begin
    dims_ok = (n != 4'd0) && (m != 4'd0)
           && (n <= DIM_LIM) && (m <= DIM_LIM);
    prod    = {4'b0000, n} * {4'b0000, m};
    total_d = dims_ok ? CW'(prod) : '0;
  end

  // Issue a read while the byte has room and cells remain;
  // cell_addr rests at 0 whenever no read is issued.
  always_comb begin
    issue = (state == GATHER)
         && ((pk_cnt + {3'b000, cap_pend}) < BYTE_LEN)
         && (cell_idx < total);
    cell_addr = issue ? cell_idx[ADDR_W-1:0] : '0;
    pk_clear  = (state == SEND) || (state == IDLE);
  end

  bit_packer u_packer (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .clear      (pk_clear),
    .shift_en   (cap_pend),
    .bit_in     (cell_val),
    .byte_out   (pk_byte),
    .count      (pk_cnt)
  );

  // State register.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic; one byte in flight until tx_done returns.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (start) nxt = HEADER;
      HEADER:    nxt = WAIT_DONE;
      GATHER:    nxt = issue ? GATHER : SEND;
      SEND:      nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done) begin
          if (last_q)              nxt = FINISH;
          else if (cell_idx < total) nxt = GATHER;
          else                     nxt = CHECKSUM;
        end
      end
      CHECKSUM:  nxt = WAIT_DONE;
      FINISH:    nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // Frame datapath and registered outputs.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      finished <= 1'b0;
      cell_idx <= '0;
      total    <= '0;
      hdr_q    <= '0;
      csum     <= '0;
      last_q   <= 1'b0;
      cap_pend <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      busy     <= (nxt != IDLE);
      finished <= (nxt == FINISH);
      cap_pend <= issue;
      if (issue) cell_idx <= cell_idx + CNT_ONE;
      unique case (state)
        IDLE: begin
          if (start) begin
            total    <= total_d;
            cell_idx <= '0;
            csum     <= '0;
            last_q   <= 1'b0;
            hdr_q    <= hdr_byte(n, m);
          end
        end
        HEADER: begin
          tx_valid <= 1'b1;
          tx_data  <= hdr_q;
          csum     <= csum_next(csum, hdr_q);
        end
        SEND: begin
          tx_valid <= 1'b1;
          tx_data  <= pk_byte;
          csum     <= csum_next(csum, pk_byte);
        end
        CHECKSUM: begin
          tx_valid <= 1'b1;
          tx_data  <= csum;
          last_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_sequencer.sv
// tb_tx_sequencer: table of boards with hand-computed frames, plus
// restart, reset-abort and stalled-transmitter sequences.
module tb_tx_sequencer;

  logic       clk_100mhz = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] n_in = 4'd0;
  logic [3:0] m_in = 4'd0;
  logic [6:0] cell_addr;
  logic       cell_val = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;
  logic       busy;
  logic       finished;

  always #5 clk_100mhz = ~clk_100mhz;

  tx_sequencer #(.MAX_DIM(11), .ADDR_W(7)) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .start      (start),
    .n          (n_in),
    .m          (m_in),
    .cell_addr  (cell_addr),
    .cell_val   (cell_val),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .busy       (busy),
    .finished   (finished)
  );

  // Synchronous board memory: data one cycle after the address.
  logic [127:0] board = '0;
  always @(posedge clk_100mhz) cell_val <= board[cell_addr];

  int cyc = 0;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  logic [7:0] got[$];
  int         gaps[$];
  int         fin_cnt = 0;
  int         overlap = 0;
  int         addr_act = 0;
  int         addr_max = 0;
  int         last_done = -1;
  bit         outst = 0;
  bit         resp_en = 1;
  int         resp_delay = 10;
  int         kick_req = 0;
  int         kick_ack = 0;
  bit         pend = 0;
  int         cnt = 0;

  // Monitor plus UART model: answers each byte with a tx_done pulse.
  always @(negedge clk_100mhz) begin
    if (rst) begin
      outst     = 0;
      last_done = -1;
    end
    if (tx_done) begin
      outst     = 0;
      last_done = cyc;
    end
    tx_done = 1'b0;
    if (tx_valid) begin
      got.push_back(tx_data);
      if (outst) overlap++;
      outst = 1;
      if (last_done >= 0) gaps.push_back(cyc - last_done);
      if (resp_en) begin
        pend = 1;
        cnt  = resp_delay - 1;
      end
    end else if (pend) begin
      if (cnt <= 0) begin
        tx_done = 1'b1;
        pend    = 0;
      end else begin
        cnt--;
      end
    end
    if (kick_req != kick_ack) begin
      kick_ack = kick_req;
      tx_done  = 1'b1;
    end
    if (finished) begin
      fin_cnt++;
      last_done = -1;
    end
    if (cell_addr != 7'd0) addr_act++;
    if (int'(cell_addr) > addr_max) addr_max = int'(cell_addr);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   n;
    logic [3:0]   m;
    logic [127:0] cells;
    int           nbytes;
    logic [143:0] exp;
    int           gap1;
    bit           inject;
    bit           no_addr;
  } vec_t;

  vec_t tv[8];

  task automatic wait_got(input int target, input int limit, output bit ok);
    int w;
    w = 0;
    while (got.size() < target && w < limit) begin
      @(negedge clk_100mhz);
      w++;
    end
    ok = (got.size() >= target);
  endtask

  task automatic pulse_start(input logic [3:0] rn, input logic [3:0] cm);
    @(negedge clk_100mhz);
    n_in  = rn;
    m_in  = cm;
    start = 1'b1;
    @(negedge clk_100mhz);
    start = 1'b0;
    n_in  = 4'hF;
    m_in  = 4'hF;
  endtask

  task automatic run_vec(input int i);
    int  gb, gpb, fb, ob, ab, w;
    bit  inj;
    logic [7:0] eb;
    string tag;
    tag   = $sformatf("vec%0d", i);
    board = tv[i].cells;
    gb    = got.size();
    gpb   = gaps.size();
    fb    = fin_cnt;
    ob    = overlap;
    ab    = addr_act;
    inj   = 0;
    pulse_start(tv[i].n, tv[i].m);
    w = 0;
    while (fin_cnt == fb && w < 6000) begin
      @(negedge clk_100mhz);
      w++;
      start = 1'b0;
      if (tv[i].inject && !inj && got.size() - gb == 4) begin
        n_in  = 4'd1;
        m_in  = 4'd1;
        start = 1'b1;
        inj   = 1;
      end
    end
    start = 1'b0;
    chk({tag, " finished_seen"}, int'(fin_cnt != fb), 1);
    repeat (4) @(negedge clk_100mhz);
    chk({tag, " nbytes"}, got.size() - gb, tv[i].nbytes);
    for (int b = 0; b < tv[i].nbytes; b++) begin
      eb = tv[i].exp[8*(tv[i].nbytes-1-b) +: 8];
      if (gb + b < got.size())
        chk($sformatf("%s byte%0d", tag, b), int'(got[gb+b]), int'(eb));
      else
        chk($sformatf("%s byte%0d missing", tag, b), 0, 1);
    end
    chk({tag, " finished_once"}, fin_cnt - fb, 1);
    chk({tag, " one_outstanding"}, overlap - ob, 0);
    chk({tag, " busy_idle"}, int'(busy), 0);
    eb = tv[i].exp[7:0];
    chk({tag, " tx_data_held"}, int'(tx_data), int'(eb));
    if (gaps.size() > gpb)
      chk({tag, " gap1"}, gaps[gpb], tv[i].gap1);
    else
      chk({tag, " gap1 missing"}, 0, 1);
    if (tv[i].no_addr)
      chk({tag, " no_addr"}, addr_act - ab, 0);
  endtask

  initial begin : main
    bit ok;
    int gb, fb, ob;

    tv[0] = '{4'd2, 4'd3, 128'h15, 3,
              144'({8'h23, 8'h15, 8'h36}), 8, 0, 0};
    tv[1] = '{4'd0, 4'd5, 128'hFF, 2,
              144'({8'h05, 8'h05}), 1, 0, 1};
    tv[2] = '{4'd11, 4'd11, 128'({121{1'b1}}), 18,
              {8'hBB, {15{8'hFF}}, 8'h01, 8'h45}, 10, 0, 0};
    tv[3] = '{4'd12, 4'd3, 128'({121{1'b1}}), 2,
              144'({8'hC3, 8'hC3}), 1, 0, 1};
    tv[4] = '{4'd1, 4'd1, 128'h1, 3,
              144'({8'h11, 8'h01, 8'h10}), 3, 0, 0};
    tv[5] = '{4'd3, 4'd3, 128'h153, 4,
              144'({8'h33, 8'h53, 8'h01, 8'h61}), 10, 0, 0};
    tv[6] = '{4'd2, 4'd4, 128'hA5, 3,
              144'({8'h24, 8'hA5, 8'h81}), 10, 0, 0};
    tv[7] = '{4'd11, 4'd11, 128'({121{1'b1}}), 18,
              {8'hBB, {15{8'hFF}}, 8'h01, 8'h45}, 10, 1, 0};

    repeat (3) @(negedge clk_100mhz);
    chk("rst tx_valid", int'(tx_valid), 0);
    chk("rst tx_data", int'(tx_data), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst finished", int'(finished), 0);
    chk("rst cell_addr", int'(cell_addr), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk_100mhz);

    for (int i = 0; i < 8; i++) begin
      resp_delay = (i == 2) ? 10 : 2 + i;
      run_vec(i);
    end
    chk("max cell_addr", addr_max, 120);

    // Reset while the third byte waits for its tx_done.
    resp_delay = 3;
    board = '1;
    gb = got.size();
    fb = fin_cnt;
    pulse_start(4'd11, 4'd11);
    wait_got(gb + 2, 500, ok);
    chk("abort two_bytes_seen", int'(ok), 1);
    resp_en = 0;
    wait_got(gb + 3, 500, ok);
    chk("abort third_byte_seen", int'(ok), 1);
    @(negedge clk_100mhz);
    chk("abort busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("abort tx_valid", int'(tx_valid), 0);
    chk("abort busy", int'(busy), 0);
    @(negedge clk_100mhz);
    rst = 1'b0;
    repeat (2) @(negedge clk_100mhz);
    kick_req++;
    repeat (40) @(negedge clk_100mhz);
    chk("abort no_more_bytes", got.size() - gb, 3);
    chk("abort busy_after_stale", int'(busy), 0);
    chk("abort no_finished", fin_cnt - fb, 0);

    // Transmitter stalls for 1000 cycles after the header.
    board = 128'h15;
    gb = got.size();
    fb = fin_cnt;
    ob = overlap;
    pulse_start(4'd2, 4'd3);
    wait_got(gb + 1, 50, ok);
    chk("stall header_seen", int'(ok), 1);
    repeat (1000) @(negedge clk_100mhz);
    chk("stall busy", int'(busy), 1);
    chk("stall no_extra_tx", got.size() - gb, 1);
    resp_en    = 1;
    resp_delay = 4;
    kick_req++;
    wait_got(gb + 3, 200, ok);
    chk("stall resumed", int'(ok), 1);
    repeat (20) @(negedge clk_100mhz);
    chk("stall nbytes", got.size() - gb, 3);
    if (got.size() >= gb + 3) begin
      chk("stall byte0", int'(got[gb]), 'h23);
      chk("stall byte1", int'(got[gb+1]), 'h15);
      chk("stall byte2", int'(got[gb+2]), 'h36);
    end else begin
      chk("stall bytes missing", 0, 1);
    end
    chk("stall finished_once", fin_cnt - fb, 1);
    chk("stall one_outstanding", overlap - ob, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
